// File: rtl/hpdcache_fifo_lvl_pkg.sv
// Shared width helpers for the level-tracking FIFO and its pointer sub-module.
package hpdcache_fifo_lvl_pkg;

  // Bits needed to count from 0 up to and including depth.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return int'($clog2(depth + 32'd1));
  endfunction

  // Bits needed to address depth entries; a single-entry FIFO still gets one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    int unsigned w;
    if (depth <= 32'd1) begin
      w = 32'd1;
    end else begin
      w = int'($clog2(depth));
    end
    return w;
  endfunction

endpackage

// File: rtl/hpdcache_fifo_lvl_chk.sv
// Runtime sanity properties for the level-tracking FIFO.
module hpdcache_fifo_lvl_chk
  import hpdcache_fifo_lvl_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LVL_W = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic [LVL_W-1:0] i_level,
  input logic             i_rexec,
  input logic             i_empty,
  input logic             i_bypass
);

  // Stored count can never exceed the number of entries.
  a_level_bounded: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (32'(i_level) <= DEPTH))
    else $error("fifo level above depth");

  // A pop from an empty FIFO is only legal as a same-cycle bypass.
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_rexec && i_empty) |-> i_bypass)
    else $error("fifo pop while empty without bypass");

endmodule

// File: rtl/hpdcache_wrap_ptr.sv
// Pointer register that increments and wraps from MAX back to zero (any MAX).
module hpdcache_wrap_ptr
  import hpdcache_fifo_lvl_pkg::*;
#(
  parameter int unsigned MAX   = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;
  logic [WIDTH-1:0] w_ptr_nxt;

  // Next pointer: synchronous clear wins, otherwise increment with wrap at MAX.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_clr) begin
      w_ptr_nxt = {WIDTH{1'b0}};
    end else if (i_inc) begin
      if (r_ptr == WIDTH'(MAX)) begin
        w_ptr_nxt = {WIDTH{1'b0}};
      end else begin
        w_ptr_nxt = r_ptr + WIDTH'(1);
      end
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Pointer state, cleared asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= {WIDTH{1'b0}};
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/hpdcache_fifo_lvl.sv
// FIFO with level count, almost-full/empty flags, sticky overflow and optional
// feed-through (same-cycle bypass when empty, write-into-full when popping).
module hpdcache_fifo_lvl
  import hpdcache_fifo_lvl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter logic        FEEDTHROUGH   = 1'b0,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRESH = 1,
  parameter type         fifo_data_t   = logic
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                w_i,
  output logic                                wok_o,
  input  fifo_data_t                          wdata_i,
  input  logic                                r_i,
  output logic                                rok_o,
  output fifo_data_t                          rdata_o,
  output logic [lvl_width(FIFO_DEPTH)-1:0]    level_o,
  output logic                                afull_o,
  output logic                                aempty_o,
  output logic                                ovf_o
);

  localparam int unsigned LVL_W = lvl_width(FIFO_DEPTH);
  localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);

  typedef logic [PTR_W-1:0] addr_t;

  fifo_data_t       r_mem [FIFO_DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  addr_t            w_rptr;
  addr_t            w_wptr;
  logic             w_full;
  logic             w_empty;
  logic             w_wok;
  logic             w_rok;
  logic             w_wexec;
  logic             w_rexec;
  logic             w_bypass;
  logic             w_store;
  logic             w_pop;

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == {LVL_W{1'b0}});

  // Feed-through lets a write in when the same cycle frees a slot, and lets a
  // read see a write when nothing is stored yet.
  assign w_wok = ~flush_i & (~w_full  | (FEEDTHROUGH & r_i));
  assign w_rok = ~flush_i & (~w_empty | (FEEDTHROUGH & w_i));

  assign w_wexec  = w_i & w_wok & ~flush_i;
  assign w_rexec  = r_i & w_rok & ~flush_i;
  assign w_bypass = FEEDTHROUGH & w_empty & w_wexec & w_rexec;
  assign w_store  = w_wexec & ~w_bypass;
  assign w_pop    = w_rexec & ~w_bypass;

  hpdcache_wrap_ptr #(
    .MAX   (FIFO_DEPTH - 1),
    .WIDTH (PTR_W)
  ) u_rptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (flush_i),
    .i_inc   (w_pop),
    .o_ptr   (w_rptr)
  );

  hpdcache_wrap_ptr #(
    .MAX   (FIFO_DEPTH - 1),
    .WIDTH (PTR_W)
  ) u_wptr (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (flush_i),
    .i_inc   (w_store),
    .o_ptr   (w_wptr)
  );

  // Level bookkeeping: flush empties, otherwise +1/-1 on store-only/pop-only.
  always_comb begin
    w_level_nxt = r_level;
    if (flush_i) begin
      w_level_nxt = {LVL_W{1'b0}};
    end else begin
      case ({w_store, w_pop})
        2'b10:   w_level_nxt = r_level + LVL_W'(1);
        2'b01:   w_level_nxt = r_level - LVL_W'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Overflow is sticky until flush; a refused write during flush is not counted.
  always_comb begin
    w_ovf_nxt = r_ovf;
    if (flush_i) begin
      w_ovf_nxt = 1'b0;
    end else if (w_i & ~w_wok) begin
      w_ovf_nxt = 1'b1;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Level and overflow state, cleared asynchronously on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_level <= {LVL_W{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Payload storage, written only when an entry is really stored; no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      r_mem[w_wptr] <= wdata_i;
    end
  end

  // Head entry, or the incoming payload when bypassing an empty feed-through FIFO.
  always_comb begin
    if (FEEDTHROUGH && w_empty) begin
      rdata_o = wdata_i;
    end else begin
      rdata_o = r_mem[w_rptr];
    end
  end

  assign wok_o    = w_wok;
  assign rok_o    = w_rok;
  assign level_o  = r_level;
  assign ovf_o    = r_ovf;
  assign afull_o  = (32'(r_level) >= AFULL_THRESH);
  assign aempty_o = (32'(r_level) <= AEMPTY_THRESH);

  hpdcache_fifo_lvl_chk #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_chk (
    .i_clk    (clk_i),
    .i_rst_n  (rst_ni),
    .i_level  (r_level),
    .i_rexec  (w_rexec),
    .i_empty  (w_empty),
    .i_bypass (w_bypass)
  );

endmodule

// File: tb/tb_hpdcache_fifo_lvl.sv
// Three FIFO configurations (3/no-FT, 4/FT, 1/FT) checked every cycle against
// queue-based reference models, plus directed corner cases.
module tb_hpdcache_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       w   [3];
  logic       r   [3];
  logic [7:0] wd  [3];
  logic       wok [3];
  logic       rok [3];
  logic [7:0] rd  [3];
  logic       af  [3];
  logic       ae  [3];
  logic       ovf [3];
  logic [1:0] lvl0;
  logic [2:0] lvl1;
  logic [0:0] lvl2;

  int          dep [3] = '{3, 4, 1};
  bit          ftp [3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0]  mq  [3][$];
  bit          movf [3];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  hpdcache_fifo_lvl #(.FIFO_DEPTH(3), .FEEDTHROUGH(1'b0), .fifo_data_t(logic [7:0])) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .w_i(w[0]), .wok_o(wok[0]),
    .wdata_i(wd[0]), .r_i(r[0]), .rok_o(rok[0]), .rdata_o(rd[0]), .level_o(lvl0),
    .afull_o(af[0]), .aempty_o(ae[0]), .ovf_o(ovf[0]));

  hpdcache_fifo_lvl #(.FIFO_DEPTH(4), .FEEDTHROUGH(1'b1), .fifo_data_t(logic [7:0])) u_d4 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .w_i(w[1]), .wok_o(wok[1]),
    .wdata_i(wd[1]), .r_i(r[1]), .rok_o(rok[1]), .rdata_o(rd[1]), .level_o(lvl1),
    .afull_o(af[1]), .aempty_o(ae[1]), .ovf_o(ovf[1]));

  hpdcache_fifo_lvl #(.FIFO_DEPTH(1), .FEEDTHROUGH(1'b1), .fifo_data_t(logic [7:0])) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .w_i(w[2]), .wok_o(wok[2]),
    .wdata_i(wd[2]), .r_i(r[2]), .rok_o(rok[2]), .rdata_o(rd[2]), .level_o(lvl2),
    .afull_o(af[2]), .aempty_o(ae[2]), .ovf_o(ovf[2]));

  function automatic int get_lvl(input int k);
    case (k)
      0:       return int'(lvl0);
      1:       return int'(lvl1);
      default: return int'(lvl2);
    endcase
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      w[k] = 1'b0;
      r[k] = 1'b0;
    end
  endtask

  task automatic clear_models();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      movf[k] = 1'b0;
    end
  endtask

  // Compare every output against the models, advance the models, move to next negedge.
  task automatic tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      int n;
      bit full, empty, ewok, erok, wex, rex, byp;
      logic [7:0] erd;
      n     = mq[k].size();
      full  = (n == dep[k]);
      empty = (n == 0);
      ewok  = !flush && (!full  || (ftp[k] && r[k]));
      erok  = !flush && (!empty || (ftp[k] && w[k]));
      chk_val($sformatf("wok%0d", k), 32'(wok[k]), 32'(ewok));
      chk_val($sformatf("rok%0d", k), 32'(rok[k]), 32'(erok));
      chk_val($sformatf("lvl%0d", k), get_lvl(k), n);
      chk_val($sformatf("afull%0d", k), 32'(af[k]), 32'(n >= dep[k] - 1));
      chk_val($sformatf("aempty%0d", k), 32'(ae[k]), 32'(n <= 1));
      chk_val($sformatf("ovf%0d", k), 32'(ovf[k]), 32'(movf[k]));
      if (erok) begin
        erd = (ftp[k] && empty) ? wd[k] : mq[k][0];
        chk_val($sformatf("rdata%0d", k), 32'(rd[k]), 32'(erd));
      end
      wex = w[k] && ewok;
      rex = r[k] && erok;
      byp = ftp[k] && empty && wex && rex;
      if (flush) begin
        mq[k].delete();
        movf[k] = 1'b0;
      end else begin
        if (w[k] && !ewok) movf[k] = 1'b1;
        if (!byp) begin
          if (rex) void'(mq[k].pop_front());
          if (wex) mq[k].push_back(wd[k]);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    for (int k = 0; k < 3; k++) wd[k] = 8'h00;
    idle();
    clear_models();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk_val($sformatf("rst_lvl%0d", k), get_lvl(k), 32'd0);
      chk_val($sformatf("rst_wok%0d", k), 32'(wok[k]), 32'd1);
      chk_val($sformatf("rst_rok%0d", k), 32'(rok[k]), 32'd0);
      chk_val($sformatf("rst_aempty%0d", k), 32'(ae[k]), 32'd1);
      chk_val($sformatf("rst_ovf%0d", k), 32'(ovf[k]), 32'd0);
    end
    chk_val("rst_afull_d3", 32'(af[0]), 32'd0);
    chk_val("rst_afull_d1", 32'(af[2]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Depth 3, no feed-through: fill, overflow, drain in order
    w[0] = 1'b1; wd[0] = 8'hA1; tick();
    wd[0] = 8'hB2; tick();
    wd[0] = 8'hC3; tick();
    wd[0] = 8'hD4;
    #1;
    chk_val("full_lvl", 32'(lvl0), 32'd3);
    chk_val("full_wok", 32'(wok[0]), 32'd0);
    chk_val("full_afull", 32'(af[0]), 32'd1);
    chk_val("full_ovf_pre", 32'(ovf[0]), 32'd0);
    tick();
    w[0] = 1'b0; r[0] = 1'b1;
    #1;
    chk_val("ovf_set", 32'(ovf[0]), 32'd1);
    chk_val("ovf_lvl", 32'(lvl0), 32'd3);
    chk_val("drain_a", 32'(rd[0]), 32'hA1);
    tick();
    chk_val("drain_b", 32'(rd[0]), 32'hB2);
    tick();
    chk_val("drain_c", 32'(rd[0]), 32'hC3);
    tick();
    idle();

    // Depth 3: one prefill then continuous write+read, pointers wrap
    w[0] = 1'b1; wd[0] = 8'h10; tick();
    r[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wd[0] = 8'(8'h20 + i);
      #1;
      chk_val("stream_lvl", 32'(lvl0), 32'd1);
      tick();
    end
    w[0] = 1'b0; tick();
    idle();

    // Depth 4, feed-through: bypass when empty
    w[1] = 1'b1; r[1] = 1'b1; wd[1] = 8'h5A;
    #1;
    chk_val("byp_rdata", 32'(rd[1]), 32'h5A);
    chk_val("byp_rok", 32'(rok[1]), 32'd1);
    tick();
    idle();
    #1;
    chk_val("byp_lvl", 32'(lvl1), 32'd0);

    // Depth 4, feed-through: write into full while popping
    w[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd[1] = 8'(8'h11 + i);
      tick();
    end
    r[1] = 1'b1; wd[1] = 8'h15;
    #1;
    chk_val("ftfull_wok", 32'(wok[1]), 32'd1);
    chk_val("ftfull_head", 32'(rd[1]), 32'h11);
    tick();
    w[1] = 1'b0;
    #1;
    chk_val("ftfull_lvl", 32'(lvl1), 32'd4);
    chk_val("ftfull_next", 32'(rd[1]), 32'h12);
    idle();

    // Flush with simultaneous write and read at level 2
    w[0] = 1'b1; wd[0] = 8'h31; tick();
    wd[0] = 8'h32; tick();
    flush = 1'b1; r[0] = 1'b1; wd[0] = 8'h33; tick();
    flush = 1'b0; idle();
    #1;
    chk_val("flush_lvl", 32'(lvl0), 32'd0);
    chk_val("flush_ovf", 32'(ovf[0]), 32'd0);
    chk_val("flush_rok", 32'(rok[0]), 32'd0);

    // Depth 1: asynchronous reset while holding an entry
    w[2] = 1'b1; wd[2] = 8'h77; tick();
    idle();
    #1;
    chk_val("d1_lvl_pre", 32'(lvl2), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_val("d1_rst_lvl", 32'(lvl2), 32'd0);
    chk_val("d1_rst_aempty", 32'(ae[2]), 32'd1);
    chk_val("d1_rst_wok", 32'(wok[2]), 32'd1);
    clear_models();
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    w[2] = 1'b1; wd[2] = 8'h88; tick();
    w[2] = 1'b0; r[2] = 1'b1;
    #1;
    chk_val("d1_after_rok", 32'(rok[2]), 32'd1);
    chk_val("d1_after_rdata", 32'(rd[2]), 32'h88);
    tick();
    idle();

    // Random traffic on all three instances
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < 3; k++) begin
        w[k]  = ($urandom_range(0, 99) < 55);
        r[k]  = ($urandom_range(0, 99) < 45);
        wd[k] = 8'($urandom);
      end
      tick();
    end
    flush = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpdcache_fifo_lvl.md
HPDCACHE_FIFO_LVL -- requirements
Module: hpdcache_fifo_lvl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: number of entries, >=1, any integer (power of two not required).
REQ-002 SHALL have parameter FEEDTHROUGH, default 1'b0: when set, allow same-cycle write-to-read bypass and write-into-full when popping.
REQ-003 SHALL have parameter AFULL_THRESH, default FIFO_DEPTH-1: almost-full level threshold.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 1: almost-empty level threshold.
REQ-005 SHALL have type parameter fifo_data_t, default logic: entry payload type.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  clock; one clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous discard of all contents.
- w_i  in  1  write request.
- wok_o  out  1  write can be accepted.
- wdata_i  in  fifo_data_t  write payload.
- r_i  in  1  read request.
- rok_o  out  1  read data valid.
- rdata_o  out  fifo_data_t  head payload.
- level_o  out  LVL_W  stored entry count, LVL_W = $clog2(FIFO_DEPTH+1).
- afull_o  out  1  level_o >= AFULL_THRESH.
- aempty_o  out  1  level_o <= AEMPTY_THRESH.
- ovf_o  out  1  sticky: write attempted while wok_o=0.

Function
REQ-007 SHALL accept write (wexec) when w_i & wok_o & ~flush_i; SHALL pop (rexec) when r_i & rok_o & ~flush_i.
REQ-008 SHALL drive wok_o = ~full | (FEEDTHROUGH & r_i); rok_o = ~empty | (FEEDTHROUGH & w_i); both 0 while flush_i=1.
REQ-009 SHALL, when empty and FEEDTHROUGH and w_i & r_i, pass wdata_i to rdata_o combinationally, store nothing, leave level unchanged.
REQ-010 SHALL drive rdata_o = wdata_i when FEEDTHROUGH and empty, else head entry; value is don't-care when rok_o=0.
REQ-011 SHALL wrap read/write pointers from FIFO_DEPTH-1 to 0 for any depth; derive full/empty from level_o (level==FIFO_DEPTH / level==0).
REQ-012 SHALL update level: +1 on store-only, -1 on pop-only, unchanged on store+pop, bypass, or neither; never exceed FIFO_DEPTH or go below 0.
REQ-013 SHALL, when full and FEEDTHROUGH with w_i & r_i, pop head and store wdata_i in same cycle; level stays FIFO_DEPTH.
REQ-014 SHALL ignore r_i when rok_o=0 and w_i when wok_o=0 (no state change except ovf_o).
REQ-015 SHALL set ovf_o one cycle after any w_i & ~wok_o & ~flush_i; hold until flush or reset.
REQ-016 SHALL on flush_i=1 reset pointers, level, ovf_o next cycle; flush has priority over simultaneous w_i/r_i (both dropped).
REQ-017 SHALL derive afull_o/aempty_o only from registered level (no combinational path from w_i/r_i).
REQ-018 SHALL support FIFO_DEPTH=1 natively: single register, same flags and semantics.
REQ-019 SHALL write storage only on stored wexec; storage needs no reset.

Reset
REQ-020 SHALL on rst_ni=0 asynchronously clear pointers, level_o=0, ovf_o=0; hence rok_o=FEEDTHROUGH&w_i, wok_o=1, aempty_o=1, afull_o=(AFULL_THRESH==0).
REQ-021 SHALL tolerate reset mid-transfer: in-flight content lost, no partial state after release.

Structure
REQ-022 SHALL keep no typedefs in a shared package; LVL_W and address type are local to the module.
REQ-023 SHALL implement pointer increment-with-wrap in one sub-module hpdcache_wrap_ptr (params MAX, width), instantiated for read and write pointers.
REQ-024 SHALL include assertions (translate_off): level never > FIFO_DEPTH; rexec never when empty without bypass.

Verification
REQ-025 DEPTH=3, FT=0: write A,B,C -> level 3, wok_o=0, afull_o=1; 4th write -> ovf_o=1 next cycle, data unchanged; reads return A,B,C.
REQ-026 DEPTH=3: 10 cycles continuous write+read after one prefill -> pointers wrap 2->0, level stays 1, order preserved.
REQ-027 FT=1, empty, w_i=r_i=1, wdata_i=0x5A -> rdata_o=0x5A, rok_o=1 same cycle, level remains 0.
REQ-028 FT=1, full DEPTH=4, w_i=r_i=1 -> head popped, new entry stored, level 4, wok_o=1.
REQ-029 level 2, flush_i with w_i=r_i=1 -> next cycle level 0, ovf_o=0, rok_o=0, pushed data not stored.
REQ-030 DEPTH=1 and rst_ni pulsed while level 1 -> level 0, aempty_o=1 asynchronously, then normal operation.
